// File: rtl/rx_stream_checker_if.sv
// AXI-Stream beat bundle between a stream source and rx_stream_checker.
interface rx_stream_checker_if #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8
);
  logic [AXIS_DATA_WIDTH-1:0] tdata;
  logic [AXIS_KEEP_WIDTH-1:0] tkeep;
  logic                       tvalid;
  logic                       tready;
  logic                       tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/rx_stream_checker.sv
// Receive-stream checker: counts packets/bytes, checks payload sequence numbers and keeps,
// and reports bytes per interval. RX_CHECKER_BACKPRESSURE_EN enables LFSR-driven tready.
module rx_stream_checker #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int LOG_INTERVAL    = 4096
) (
  input  logic                clk,
  input  logic                rst,
  rx_stream_checker_if.slave  s_axis,
  input  logic                clear_stats,
  output logic [31:0]         pkt_count,
  output logic [63:0]         byte_count,
  output logic [31:0]         err_count,
  output logic                err_flag,
  output logic [31:0]         interval_bytes,
  output logic                interval_valid
);

  localparam int CNT_W = (LOG_INTERVAL > 1) ? $clog2(LOG_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOG_INTERVAL - 1);

  typedef enum logic [1:0] {ST_HDR = 2'd0, ST_SEQ = 2'd1, ST_DATA = 2'd2} state_e;

  function automatic logic [31:0] popcount(input logic [AXIS_KEEP_WIDTH-1:0] v);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  state_e          state_r, state_s;
  logic [63:0]     base_r, base_s;
  logic [31:0]     index_r, index_s;
  logic            data_err_s;
  logic            keep_err_s;
  logic            err_beat_s;
  logic            ready_s;
  logic            accept_s;
  logic            counted_s;
  logic [31:0]     beat_bytes_s;
  logic [31:0]     add_bytes_s;

  logic [31:0]     pkt_count_r;
  logic [63:0]     byte_count_r;
  logic [31:0]     err_count_r;
  logic            err_flag_r;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [31:0]     accum_r;
  logic [31:0]     interval_bytes_r;
  logic            interval_valid_r;

`ifdef RX_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr_r;

  // Free-running x^16+x^14+x^13+x^11+1 LFSR pacing tready.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  assign ready_s = ~rst & (lfsr_r[6:0] < 7'd100);
`else
  assign ready_s = ~rst;
`endif

  assign s_axis.tready = ready_s;
  assign accept_s      = s_axis.tvalid & ready_s;
  // A beat taken together with clear_stats still steers the FSM but adds to no count.
  assign counted_s     = accept_s & ~clear_stats;
  assign beat_bytes_s  = popcount(s_axis.tkeep);
  assign add_bytes_s   = counted_s ? beat_bytes_s : 32'd0;
  assign keep_err_s    = accept_s & ~s_axis.tlast & ~(&s_axis.tkeep);
  assign err_beat_s    = data_err_s | keep_err_s;

  generate
    if (AXIS_DATA_WIDTH > 64) begin : g_unused
      logic unused_tdata_s;
      assign unused_tdata_s = ^s_axis.tdata[AXIS_DATA_WIDTH-1:64];
    end
  endgenerate

  // Packet FSM state, sequence base and beat index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_HDR;
      base_r  <= 64'd0;
      index_r <= 32'd0;
    end else begin
      state_r <= state_s;
      base_r  <= base_s;
      index_r <= index_s;
    end
  end

  // Next-state and payload sequence check.
  always_comb begin
    state_s    = state_r;
    base_s     = base_r;
    index_s    = index_r;
    data_err_s = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_HDR: begin
          state_s = s_axis.tlast ? ST_HDR : ST_SEQ;
        end
        ST_SEQ: begin
          base_s  = s_axis.tdata[63:0] - 64'd1;
          index_s = 32'd2;
          state_s = s_axis.tlast ? ST_HDR : ST_DATA;
        end
        ST_DATA: begin
          data_err_s = (s_axis.tdata[63:0] != (base_r + {32'd0, index_r}));
          index_s    = index_r + 32'd1;
          state_s    = s_axis.tlast ? ST_HDR : ST_DATA;
        end
        default: begin
          state_s = ST_HDR;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Packet, byte and error statistics.
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      pkt_count_r  <= 32'd0;
      byte_count_r <= 64'd0;
      err_count_r  <= 32'd0;
      err_flag_r   <= 1'b0;
    end else if (accept_s) begin
      byte_count_r <= byte_count_r + {32'd0, beat_bytes_s};
      if (s_axis.tlast) begin
        pkt_count_r <= pkt_count_r + 32'd1;
      end
      if (err_beat_s) begin
        err_flag_r <= 1'b1;
        if (err_count_r != 32'hFFFF_FFFF) begin
          err_count_r <= err_count_r + 32'd1;
        end
      end
    end
  end

  // Throughput interval: free-running cycle counter and byte accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_r      <= {CNT_W{1'b0}};
      accum_r          <= 32'd0;
      interval_bytes_r <= 32'd0;
      interval_valid_r <= 1'b0;
    end else begin
      cycle_cnt_r      <= cycle_cnt_r + CNT_W'(1);
      interval_valid_r <= (cycle_cnt_r == CNT_LAST);
      if (cycle_cnt_r == CNT_LAST) begin
        interval_bytes_r <= accum_r + add_bytes_s;
        accum_r          <= 32'd0;
      end else if (clear_stats) begin
        accum_r <= 32'd0;
      end else begin
        accum_r <= accum_r + add_bytes_s;
      end
    end
  end

  assign pkt_count      = pkt_count_r;
  assign byte_count     = byte_count_r;
  assign err_count      = err_count_r;
  assign err_flag       = err_flag_r;
  assign interval_bytes = interval_bytes_r;
  assign interval_valid = interval_valid_r;

endmodule

// File: tb/tb_rx_stream_checker.sv
// Self-checking bench for rx_stream_checker: directed scenarios then random traffic,
// compared every cycle against a packet-level reference model.
module tb_rx_stream_checker;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int LI = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_stats;
  logic [31:0] pkt_count;
  logic [63:0] byte_count;
  logic [31:0] err_count;
  logic        err_flag;
  logic [31:0] interval_bytes;
  logic        interval_valid;

  always #5 clk = ~clk;

  rx_stream_checker_if #(.AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW)) axis ();

  rx_stream_checker #(.AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .LOG_INTERVAL(LI)) dut (
    .clk(clk), .rst(rst), .s_axis(axis), .clear_stats(clear_stats),
    .pkt_count(pkt_count), .byte_count(byte_count), .err_count(err_count),
    .err_flag(err_flag), .interval_bytes(interval_bytes), .interval_valid(interval_valid)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: position in packet (0 header, 1 first payload, 2 later) and next expected seq.
  int          m_pos;
  logic [63:0] m_next;
  logic [31:0] m_pkt, m_err, m_acc, m_ib;
  logic [63:0] m_bytes;
  logic        m_flag, m_iv;
  int          m_cyc;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(output logic accepted);
    logic        rdy, last_b, err_b;
    logic [31:0] pc;
    logic [63:0] d;
    #1;
    rdy = axis.tready;
    if (rst) check_val("tready_in_reset", {63'd0, rdy}, 64'd0);
`ifndef RX_CHECKER_BACKPRESSURE_EN
    else check_val("tready_idle_high", {63'd0, rdy}, 64'd1);
`endif
    @(posedge clk);
    accepted = 1'b0;
    if (rst) begin
      m_pos = 0; m_next = 64'd0; m_pkt = 32'd0; m_err = 32'd0; m_acc = 32'd0;
      m_ib = 32'd0; m_bytes = 64'd0; m_flag = 1'b0; m_iv = 1'b0; m_cyc = 0;
    end else begin
      accepted = axis.tvalid && rdy;
      pc       = $countones(axis.tkeep);
      last_b   = axis.tlast;
      d        = axis.tdata[63:0];
      err_b    = 1'b0;
      if (accepted) begin
        if (!last_b && axis.tkeep != {KW{1'b1}}) err_b = 1'b1;
        if (m_pos >= 2 && d != m_next) err_b = 1'b1;
        if (m_pos == 1) m_next = d + 64'd1;
        else if (m_pos >= 2) m_next = m_next + 64'd1;
        m_pos = last_b ? 0 : ((m_pos == 0) ? 1 : 2);
      end
      m_iv = (m_cyc == LI - 1);
      if (m_iv) begin
        m_ib  = m_acc + ((accepted && !clear_stats) ? pc : 32'd0);
        m_acc = 32'd0;
      end else if (clear_stats) begin
        m_acc = 32'd0;
      end else if (accepted) begin
        m_acc = m_acc + pc;
      end
      m_cyc = (m_cyc + 1) % LI;
      if (clear_stats) begin
        m_pkt = 32'd0; m_bytes = 64'd0; m_err = 32'd0; m_flag = 1'b0;
      end else if (accepted) begin
        m_bytes = m_bytes + {32'd0, pc};
        if (last_b) m_pkt = m_pkt + 32'd1;
        if (err_b) begin
          m_flag = 1'b1;
          if (m_err != 32'hFFFF_FFFF) m_err = m_err + 32'd1;
        end
      end
    end
    #1;
    check_val("pkt_count", {32'd0, pkt_count}, {32'd0, m_pkt});
    check_val("byte_count", byte_count, m_bytes);
    check_val("err_count", {32'd0, err_count}, {32'd0, m_err});
    check_val("err_flag", {63'd0, err_flag}, {63'd0, m_flag});
    check_val("interval_bytes", {32'd0, interval_bytes}, {32'd0, m_ib});
    check_val("interval_valid", {63'd0, interval_valid}, {63'd0, m_iv});
  endtask

  task automatic fill_data(input logic [63:0] low);
    for (int i = 2; i < DW / 32; i++) axis.tdata[i*32 +: 32] = $urandom;
    axis.tdata[63:0] = low;
  endtask

  task automatic beat(input logic [63:0] low, input logic [KW-1:0] keep, input logic last);
    logic acc;
    int   n;
    fill_data(low);
    axis.tkeep  = keep;
    axis.tlast  = last;
    axis.tvalid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      step(acc);
      n++;
    end
    if (!acc) check_val("beat_accept_timeout", 64'd0, 64'd1);
    axis.tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    axis.tvalid = 1'b0;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_stats = 1'b1;
    idle(1);
    clear_stats = 1'b0;
  endtask

  localparam logic [KW-1:0] FULL = {KW{1'b1}};

  initial begin
    logic acc;
    int   pulses;
    rst = 1'b1; clear_stats = 1'b0;
    axis.tdata = '0; axis.tkeep = '0; axis.tvalid = 1'b0; axis.tlast = 1'b0;
    do_reset();
    check_val("reset_pkt", {32'd0, pkt_count}, 64'd0);
    check_val("reset_flag", {63'd0, err_flag}, 64'd0);

    // Clean 4-beat packet.
    beat(64'hDEAD, FULL, 1'b0); beat(64'h11, FULL, 1'b0);
    beat(64'h12, FULL, 1'b0);   beat(64'h13, FULL, 1'b1);
    check_val("pkt4_pkt", {32'd0, pkt_count}, 64'd1);
    check_val("pkt4_bytes", byte_count, 64'd256);
    check_val("pkt4_err", {32'd0, err_count}, 64'd0);

    // Sequence gap.
    pulse_clear();
    beat(64'h0, FULL, 1'b0); beat(64'h20, FULL, 1'b0); beat(64'h22, FULL, 1'b1);
    check_val("gap_err", {32'd0, err_count}, 64'd1);
    check_val("gap_flag", {63'd0, err_flag}, 64'd1);
    check_val("gap_pkt", {32'd0, pkt_count}, 64'd1);

    // Single-beat partial packet, then a clean 2-beat packet proves FSM is back in header.
    pulse_clear();
    beat(64'h5, 64'h0F, 1'b1);
    check_val("single_pkt", {32'd0, pkt_count}, 64'd1);
    check_val("single_bytes", byte_count, 64'd4);
    beat(64'h77, FULL, 1'b0); beat(64'h99, FULL, 1'b1);
    check_val("single_then_err", {32'd0, err_count}, 64'd0);

    // Partial keep on non-last beats, clear in between.
    pulse_clear();
    beat(64'h1, FULL, 1'b0); beat(64'h5, 64'hFFFF_FFFF, 1'b0);
    check_val("keep_err1", {32'd0, err_count}, 64'd1);
    pulse_clear();
    beat(64'h6, 64'hFFFF_FFFF, 1'b0);
    check_val("keep_err_after_clear", {32'd0, err_count}, 64'd1);
    beat(64'h7, FULL, 1'b1);

    // Throughput interval with one full beat every cycle.
    do_reset();
    pulses = 0;
    axis.tkeep = FULL; axis.tlast = 1'b1; axis.tvalid = 1'b1;
    for (int i = 0; i < 4 * LI; i++) begin
      fill_data({$urandom, $urandom});
      step(acc);
      if (interval_valid) begin
        pulses++;
        check_val("interval_full_bytes", {32'd0, interval_bytes}, 64'd1024);
      end
    end
    axis.tvalid = 1'b0;
    check_val("interval_pulses", 64'(pulses), 64'd4);

    // Reset mid-packet, then a fresh 2-beat packet.
    do_reset();
    beat(64'hAB, FULL, 1'b0); beat(64'h100, FULL, 1'b0);
    do_reset();
    beat(64'hCD, FULL, 1'b0); beat(64'h7, FULL, 1'b1);
    check_val("rst_mid_pkt", {32'd0, pkt_count}, 64'd1);
    check_val("rst_mid_err", {32'd0, err_count}, 64'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 499) == 0);
      clear_stats = ($urandom_range(0, 49) == 0);
      axis.tvalid = ($urandom_range(0, 3) != 0);
      axis.tlast  = ($urandom_range(0, 4) == 0);
      axis.tkeep  = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : FULL;
      fill_data((m_pos >= 2 && $urandom_range(0, 9) != 0) ? m_next : {$urandom, $urandom});
      step(acc);
    end
    rst = 1'b0; clear_stats = 1'b0; axis.tvalid = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rx_stream_checker.md
RX_STREAM_CHECKER -- requirements
Module: rx_stream_checker

Interface
REQ-001 Parameter AXIS_DATA_WIDTH, default 512, stream data width in bits.
REQ-002 Parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8, byte-enable width.
REQ-003 Parameter LOG_INTERVAL, default 4096, cycles per throughput interval; power of two, at least 2.
REQ-004 Port clk, input, 1, sole clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port s_axis_tdata, input, AXIS_DATA_WIDTH, beat data from panic m_rx_axis output.
REQ-007 Port s_axis_tkeep, input, AXIS_KEEP_WIDTH, byte enables.
REQ-008 Port s_axis_tvalid, input, 1, beat valid.
REQ-009 Port s_axis_tready, output, 1, beat accept.
REQ-010 Port s_axis_tlast, input, 1, final beat of packet.
REQ-011 Port clear_stats, input, 1, synchronous clear of all counters and the sticky error flag.
REQ-012 Port pkt_count, output, 32, packets accepted (wraps).
REQ-013 Port byte_count, output, 64, bytes accepted (wraps).
REQ-014 Port err_count, output, 32, error beats; saturates at 0xFFFFFFFF.
REQ-015 Port err_flag, output, 1, sticky: any error since reset or clear.
REQ-016 Port interval_bytes, output, 32, bytes accepted in the last complete interval.
REQ-017 Port interval_valid, output, 1, one-cycle pulse when interval_bytes updates.

Function
REQ-018 Beat accepted iff s_axis_tvalid and s_axis_tready are both high in the same cycle; no other cycle SHALL change any count.
REQ-019 Beat bytes = popcount(s_axis_tkeep); byte_count and the interval accumulator SHALL add this value per accepted beat.
REQ-020 FSM states: HDR (expect header beat), SEQ (expect first payload beat), DATA (further payload beats).
REQ-021 HDR: accepted beat with tlast -> count packet, stay in HDR; without tlast -> SEQ; header content is never checked.
REQ-022 SEQ: capture base = tdata[63:0] - 1 and set beat index to 2; tlast -> HDR and count packet; else -> DATA.
REQ-023 DATA: expected value = base + index, zero-extended; mismatch on tdata[63:0] SHALL be an error; index increments per beat; tlast -> HDR and count packet.
REQ-024 Any accepted non-tlast beat with tkeep not all-ones SHALL be an error in every state; partial tkeep on a tlast beat is legal.
REQ-025 A beat carrying both a data error and a keep error SHALL add exactly 1 to err_count.
REQ-026 pkt_count SHALL increment once per accepted tlast beat.
REQ-027 Interval cycle counter runs 0..LOG_INTERVAL-1 continuously and wraps.
REQ-028 In the cycle the counter equals LOG_INTERVAL-1: interval_bytes <= accumulator + this cycle's beat bytes; accumulator <= 0; interval_valid high in the following cycle only.
REQ-029 interval_bytes and the accumulator SHALL truncate to 32 bits.
REQ-030 clear_stats zeroes pkt_count, byte_count, err_count, err_flag and the accumulator; a beat accepted in the same cycle is not counted but still advances the FSM; the interval counter and FSM are unaffected.
REQ-031 All outputs are registered; counts reflect a beat one cycle after acceptance.

Reset
REQ-032 rst SHALL force: FSM to HDR, base and index to 0, all counters to 0, err_flag 0, interval_bytes 0, interval_valid 0, interval counter 0.
REQ-033 rst mid-packet SHALL discard the packet; the next accepted beat is treated as a header.
REQ-034 s_axis_tready SHALL be 0 while rst is high.

Configuration
REQ-035 Macro RX_CHECKER_BACKPRESSURE_EN: when defined, s_axis_tready is driven by a 16-bit LFSR (seed 0xACE1, advanced every cycle) and is high when the low 7 bits are below 100; when undefined, s_axis_tready is constant 1 outside reset.

Verification
REQ-036 4-beat packet, header then payload 0x11,0x12,0x13 with full keep -> pkt_count=1, byte_count=256, err_count=0.
REQ-037 3-beat packet with payload 0x20,0x22 -> err_count=1, err_flag=1, pkt_count=1.
REQ-038 Single-beat packet with tlast on header and tkeep=0x0F -> pkt_count=1, byte_count=4, FSM back in HDR.
REQ-039 Non-last payload beat with tkeep=0xFFFF_FFFF -> err_count+1; two bad beats with clear_stats pulsed between -> err_count=1 after clear.
REQ-040 LOG_INTERVAL=16, one full beat every cycle -> interval_valid once per 16 cycles with interval_bytes=1024.
REQ-041 rst asserted after the second beat of a 4-beat packet, then a fresh 2-beat packet -> pkt_count=1, err_count=0.
